pend_prio_encoder: RTL and testbench
====================================

Name: pend_prio_encoder

Overview:
- Parametrised, registered N-to-log2(N) priority encoder with event capture.
- Input request pulses are latched into a pending register. The encoded index of the winning pending request is issued through a valid/ready output stage, one index per handshake.
- Used as the interrupt/event encoder feeding the sequencer. Generalises the fixed 4:2 combinational encoder with:
  - configurable input width and priority direction;
  - masking;
  - backpressure;
  - overflow reporting.

Parameters:
- N, 8, number of request inputs (≥1).
- PRIO, 0, priority direction: 0 = lowest index wins, 1 = highest index wins.
- W, (N>1 ? $clog2(N) : 1), derived localparam; index width, not overridable.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_in  in  N  request pulses; bit i high in a cycle = one event on line i.
- mask  in  N  enable per line; 1 = eligible for issue, 0 = held pending.
- out_idx  out  W  encoded index of issued event.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts out_idx this cycle.
- pending  out  N  events captured but not yet moved into the output stage.
- overflow  out  1  sticky: an event was merged into an already-pending bit.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Reset (rst=1 at an edge):
  - pending=0, out_valid=0, out_idx=0, overflow=0.
  - req_in is ignored in reset cycles.
  - Reset mid-handshake drops the in-flight index and all pending events.
- Load condition: load = !out_valid || out_ready, evaluated each cycle.
- Candidate selection:
  - cand = pending & mask.
  - sel = lowest set bit of cand (PRIO=0) or highest set bit (PRIO=1).
  - grab = onehot(sel) if load && |cand, else 0.
- Output stage:
  - If load: out_valid <= |cand, and out_idx <= sel when |cand.
  - When |cand=0, out_idx holds its old value.
  - If !load: out_valid and out_idx hold stable. No change while out_valid && !out_ready.
- Pending update: pending <= (pending & ~grab) | req_in.
  - A req_in bit on the same index as grab in the same cycle remains pending; it is a new event and is not lost.
- Overflow:
  - Set when any i has req_in[i] && pending[i] && !grab[i].
  - Sticky; cleared by clr_ovf or rst.
  - If clr_ovf and a new overflow coincide, set wins.
- Latency:
  - req_in at cycle t → pending at t+1 → out_valid at t+2 (output idle, line unmasked).
  - Back-to-back issue at one index per cycle when out_ready=1.
- Masking:
  - Masked lines keep accumulating in pending but never issue.
  - Unmasking makes a line eligible on the same cycle.
  - Mask does not affect an index already in the output stage.
- Boundary conditions:
  - All-zero cand: out_valid drops to 0 after the current index is accepted. No bubble is required otherwise.
  - N=1: out_idx is constantly 0, W=1.

Decomposition:
- Shared package holds:
  - PRIO_LOW=0 and PRIO_HIGH=1 constants;
  - the width function used for W.
- One combinational sub-module, prio_enc_comb:
  - parameters N and PRIO;
  - inputs: vector;
  - outputs: index, found flag, onehot.
- Pending register, output stage and overflow logic stay in the top level.

Test Plan:
1. Reset: rst=1 for 3 cycles with req_in=8'hFF → after release, pending=0, out_valid=0, out_idx=0, overflow=0.
2. Issue order: PRIO=0, mask=8'hFF, out_ready=1, req_in=8'h24 for one cycle at t → out_valid with idx 2 at t+2, idx 5 at t+3, out_valid=0 at t+4.
3. Backpressure: same stimulus, out_ready=0 → idx 2 held stable with out_valid=1 for 5 cycles and pending=8'h20; raise out_ready → idx 5 next cycle.
4. Masking: mask=8'hFB, req_in=8'h04 → no issue and pending=8'h04 for 10 cycles; set mask=8'hFF → idx 2 issued the following cycle.
5. Overflow and re-request:
   - req bit 3 on two consecutive cycles while the output is stalled → overflow=1; pulse clr_ovf → overflow=0.
   - req bit 3 on the cycle idx 3 is grabbed → pending[3]=1 afterwards and overflow stays 0.
6. PRIO=1, req_in=8'h81 → idx 7 then idx 0; N=1 build → every event issues out_idx=0.

Source files
------------

// File: rtl/pend_prio_encoder_pkg.sv
// Shared constants and helpers for the pending-event priority encoder.
// PRIO_LOW/PRIO_HIGH select which end of the request vector wins arbitration.
package pend_prio_encoder_pkg;

    localparam int PRIO_LOW  = 0;
    localparam int PRIO_HIGH = 1;

    // Index width; a single-line encoder still carries a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pend_prio_encoder_if.sv
// Valid/ready index channel from the encoder to its consumer.
interface pend_prio_encoder_if
    import pend_prio_encoder_pkg::*;
#(
    parameter int N = 8
);
    localparam int W = idx_width(N);

    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;

    modport master (output out_idx, output out_valid, input  out_ready);
    modport slave  (input  out_idx, input  out_valid, output out_ready);
endinterface

// File: rtl/pend_prio_encoder_prio_enc_comb.sv
// Combinational priority encoder: index, found flag and one-hot of the winning bit.
module prio_enc_comb
    import pend_prio_encoder_pkg::*;
#(
    parameter int N    = 8,
    parameter int PRIO = PRIO_LOW
) (
    input  logic [N-1:0]            vector,
    output logic [idx_width(N)-1:0] index,
    output logic                    found,
    output logic [N-1:0]            onehot
);
    localparam int W = idx_width(N);

    always_comb begin
        index  = '0;
        found  = 1'b0;
        onehot = '0;
        if (PRIO == PRIO_LOW) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (vector[i] && !found) begin
                    found = 1'b1;
                    index = W'(i);
                end
            end
        end else begin
            // Ascending scan: the last set bit seen is the highest one.
            for (int unsigned i = 0; i < N; i++) begin
                if (vector[i]) begin
                    found = 1'b1;
                    index = W'(i);
                end
            end
        end
        if (found) begin
            onehot[index] = 1'b1;
        end
    end

endmodule

// File: rtl/pend_prio_encoder.sv
// Registered N-to-log2(N) priority encoder: request pulses are captured as pending
// events and issued one index per valid/ready handshake, with sticky overflow.
module pend_prio_encoder
    import pend_prio_encoder_pkg::*;
#(
    parameter int N    = 8,
    parameter int PRIO = PRIO_LOW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req_in,
    input  logic [N-1:0]              mask,
    output logic [N-1:0]              pending,
    output logic                      overflow,
    input  logic                      clr_ovf,
    pend_prio_encoder_if.master       out_if
);
    localparam int W = idx_width(N);

    logic [N-1:0] pending_q, pending_d;
    logic [W-1:0] out_idx_q, out_idx_d;
    logic         out_valid_q, out_valid_d;
    logic         overflow_q, overflow_d;

    logic [N-1:0] cand, grab, sel_onehot;
    logic [W-1:0] sel;
    logic         found, load;

    assign cand = pending_q & mask;

    prio_enc_comb #(
        .N    (N),
        .PRIO (PRIO)
    ) u_enc (
        .vector (cand),
        .index  (sel),
        .found  (found),
        .onehot (sel_onehot)
    );

    always_comb begin
        load        = !out_valid_q || out_if.out_ready;
        grab        = (load && found) ? sel_onehot : '0;
        out_valid_d = load ? found : out_valid_q;
        out_idx_d   = (load && found) ? sel : out_idx_q;
        // A new request on the bit being grabbed this cycle stays pending as a fresh event.
        pending_d   = (pending_q & ~grab) | req_in;
        if (|(req_in & pending_q & ~grab)) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pending          = pending_q;
    assign overflow         = overflow_q;
    assign out_if.out_idx   = out_idx_q;
    assign out_if.out_valid = out_valid_q;

endmodule

// File: tb/tb_pend_prio_encoder.sv
// Directed bench for pend_prio_encoder: N=8 low/high priority builds and an N=1 build.
module tb_pend_prio_encoder;
    import pend_prio_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Main DUT: N=8, lowest index wins
    logic [7:0] req_l = '0, mask_l = '1, pend_l;
    logic       ovf_l, clr_l = 1'b0;
    pend_prio_encoder_if #(.N(8)) if_l ();

    pend_prio_encoder #(.N(8), .PRIO(PRIO_LOW)) dut_l (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_l),
        .mask     (mask_l),
        .pending  (pend_l),
        .overflow (ovf_l),
        .clr_ovf  (clr_l),
        .out_if   (if_l.master)
    );

    // N=8, highest index wins
    logic [7:0] req_h = '0, mask_h = '1, pend_h;
    logic       ovf_h, clr_h = 1'b0;
    pend_prio_encoder_if #(.N(8)) if_h ();

    pend_prio_encoder #(.N(8), .PRIO(PRIO_HIGH)) dut_h (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_h),
        .mask     (mask_h),
        .pending  (pend_h),
        .overflow (ovf_h),
        .clr_ovf  (clr_h),
        .out_if   (if_h.master)
    );

    // N=1 build
    logic [0:0] req_1 = '0, mask_1 = '1, pend_1;
    logic       ovf_1, clr_1 = 1'b0;
    pend_prio_encoder_if #(.N(1)) if_1 ();

    pend_prio_encoder #(.N(1), .PRIO(PRIO_LOW)) dut_1 (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_1),
        .mask     (mask_1),
        .pending  (pend_1),
        .overflow (ovf_1),
        .clr_ovf  (clr_1),
        .out_if   (if_1.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if_l.out_ready = 1'b1;
        if_h.out_ready = 1'b1;
        if_1.out_ready = 1'b1;
        #1;

        // 1: reset with all requests asserted
        rst   = 1'b1;
        req_l = 8'hFF;
        repeat (3) step();
        rst   = 1'b0;
        req_l = 8'h00;
        check("rst_pending", 32'(pend_l), 32'h00);
        check("rst_valid",   32'(if_l.out_valid), 32'd0);
        check("rst_idx",     32'(if_l.out_idx), 32'd0);
        check("rst_ovf",     32'(ovf_l), 32'd0);

        // 2: issue order, no backpressure
        req_l = 8'h24;
        step();
        req_l = 8'h00;
        check("ord_pend_t1",  32'(pend_l), 32'h24);
        check("ord_valid_t1", 32'(if_l.out_valid), 32'd0);
        step();
        check("ord_valid_t2", 32'(if_l.out_valid), 32'd1);
        check("ord_idx_t2",   32'(if_l.out_idx), 32'd2);
        check("ord_pend_t2",  32'(pend_l), 32'h20);
        step();
        check("ord_valid_t3", 32'(if_l.out_valid), 32'd1);
        check("ord_idx_t3",   32'(if_l.out_idx), 32'd5);
        step();
        check("ord_valid_t4", 32'(if_l.out_valid), 32'd0);
        check("ord_pend_t4",  32'(pend_l), 32'h00);

        // 3: backpressure holds the output stable
        if_l.out_ready = 1'b0;
        req_l = 8'h24;
        step();
        req_l = 8'h00;
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(if_l.out_valid), 32'd1);
            check("bp_idx",   32'(if_l.out_idx), 32'd2);
            check("bp_pend",  32'(pend_l), 32'h20);
            step();
        end
        if_l.out_ready = 1'b1;
        step();
        check("bp_rel_valid", 32'(if_l.out_valid), 32'd1);
        check("bp_rel_idx",   32'(if_l.out_idx), 32'd5);
        step();
        check("bp_drain", 32'(if_l.out_valid), 32'd0);

        // 4: masked line accumulates, issues once unmasked
        mask_l = 8'hFB;
        req_l  = 8'h04;
        step();
        req_l  = 8'h00;
        for (int i = 0; i < 10; i++) begin
            check("msk_pend",  32'(pend_l), 32'h04);
            check("msk_valid", 32'(if_l.out_valid), 32'd0);
            step();
        end
        mask_l = 8'hFF;
        step();
        check("unmsk_valid", 32'(if_l.out_valid), 32'd1);
        check("unmsk_idx",   32'(if_l.out_idx), 32'd2);
        check("unmsk_pend",  32'(pend_l), 32'h00);
        step();
        check("unmsk_drain", 32'(if_l.out_valid), 32'd0);

        // 5a: overflow while the output is stalled
        if_l.out_ready = 1'b0;
        req_l = 8'h01;
        step();
        req_l = 8'h00;
        step();
        check("ovf_stall_idx", 32'(if_l.out_idx), 32'd0);
        check("ovf_stall_vld", 32'(if_l.out_valid), 32'd1);
        req_l = 8'h08;
        step();
        check("ovf_first", 32'(ovf_l), 32'd0);
        step();
        req_l = 8'h00;
        check("ovf_set",  32'(ovf_l), 32'd1);
        check("ovf_pend", 32'(pend_l), 32'h08);
        req_l = 8'h08;
        clr_l = 1'b1;
        step();
        check("ovf_set_wins", 32'(ovf_l), 32'd1);
        req_l = 8'h00;
        step();
        clr_l = 1'b0;
        check("ovf_clr", 32'(ovf_l), 32'd0);

        // 5b: re-request on the cycle bit 3 is grabbed
        if_l.out_ready = 1'b1;
        req_l = 8'h08;
        step();
        req_l = 8'h00;
        check("rereq_idx",  32'(if_l.out_idx), 32'd3);
        check("rereq_pend", 32'(pend_l), 32'h08);
        check("rereq_ovf",  32'(ovf_l), 32'd0);
        step();
        check("rereq_idx2", 32'(if_l.out_idx), 32'd3);
        check("rereq_vld2", 32'(if_l.out_valid), 32'd1);
        check("rereq_pnd2", 32'(pend_l), 32'h00);
        step();
        check("rereq_drain", 32'(if_l.out_valid), 32'd0);

        // 6a: highest index wins
        req_h = 8'h81;
        step();
        req_h = 8'h00;
        step();
        check("hi_idx7", 32'(if_h.out_idx), 32'd7);
        check("hi_vld7", 32'(if_h.out_valid), 32'd1);
        step();
        check("hi_idx0", 32'(if_h.out_idx), 32'd0);
        check("hi_vld0", 32'(if_h.out_valid), 32'd1);
        step();
        check("hi_drain", 32'(if_h.out_valid), 32'd0);

        // 6b: single-line build
        req_1 = 1'b1;
        step();
        check("n1_pend", 32'(pend_1), 32'd1);
        step();
        req_1 = 1'b0;
        check("n1_vld_a",  32'(if_1.out_valid), 32'd1);
        check("n1_idx_a",  32'(if_1.out_idx), 32'd0);
        check("n1_pend_a", 32'(pend_1), 32'd1);
        check("n1_ovf",    32'(ovf_1), 32'd0);
        step();
        check("n1_vld_b",  32'(if_1.out_valid), 32'd1);
        check("n1_idx_b",  32'(if_1.out_idx), 32'd0);
        check("n1_pend_b", 32'(pend_1), 32'd0);
        step();
        check("n1_drain", 32'(if_1.out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
